// File: rtl/pong_pkg.sv
// Shared state encodings, winner codes and sizing helper for the Pong match controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SERVE = 3'd2,
    ST_PLAY  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick on the VSync falling edge; single edge register, no backpressure.
// The tick is suppressed for the first cycle after reset release.
module frame_tick_gen (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_VSync,
  output logic o_Tick
);

  logic r_VSync_Prev;
  logic r_Run;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_VSync_Prev <= 1'b1;
      r_Run        <= 1'b0;
    end else begin
      r_VSync_Prev <= i_VSync;
      r_Run        <= 1'b1;
    end
  end

  assign o_Tick = r_Run & r_VSync_Prev & ~i_VSync;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: arm, serve delay, play, scoring and game-over hold.
// Outputs are registered and change on the clock after the deciding input; no backpressure.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_LIMIT  = 9,
  parameter int ARM_FRAMES   = 30,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 300
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_VSync,
  input  logic       i_Start_A_L,
  input  logic       i_Start_B_L,
  input  logic       i_P1_Miss,
  input  logic       i_P2_Miss,
  output logic       o_Game_Active,
  output logic       o_Serve_To_P2,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  localparam int CNT_W = $clog2(max3(ARM_FRAMES, SERVE_FRAMES, OVER_FRAMES)) + 1;
  localparam logic [CNT_W-1:0] LAST_ARM   = CNT_W'(ARM_FRAMES - 1);
  localparam logic [CNT_W-1:0] LAST_SERVE = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] LAST_OVER  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [3:0]       LIMIT      = 4'(SCORE_LIMIT);

  state_t           r_State;
  logic [CNT_W-1:0] r_Cnt;
  logic [3:0]       r_P1_Score;
  logic [3:0]       r_P2_Score;
  logic [1:0]       r_Winner;
  logic             r_Active;
  logic             r_Serve_To_P2;

  logic       w_Tick;
  logic [3:0] w_P1_Next;
  logic [3:0] w_P2_Next;

  frame_tick_gen u_tick (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_VSync (i_VSync),
    .o_Tick  (w_Tick)
  );

  assign w_P1_Next = (r_P1_Score >= LIMIT) ? LIMIT : r_P1_Score + 4'd1;
  assign w_P2_Next = (r_P2_Score >= LIMIT) ? LIMIT : r_P2_Score + 4'd1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State       <= ST_IDLE;
      r_Cnt         <= '0;
      r_P1_Score    <= 4'd0;
      r_P2_Score    <= 4'd0;
      r_Winner      <= WIN_NONE;
      r_Active      <= 1'b0;
      r_Serve_To_P2 <= 1'b1;
    end else begin
      case (r_State)
        ST_IDLE: begin
          if (!i_Start_A_L && !i_Start_B_L) begin
            r_State <= ST_ARM;
            r_Cnt   <= '0;
          end
        end
        ST_ARM: begin
          // A release wins over a coincident tick.
          if (i_Start_A_L || i_Start_B_L) begin
            r_State <= ST_IDLE;
          end else if (w_Tick) begin
            if (r_Cnt == LAST_ARM) begin
              r_State       <= ST_SERVE;
              r_Cnt         <= '0;
              r_P1_Score    <= 4'd0;
              r_P2_Score    <= 4'd0;
              r_Winner      <= WIN_NONE;
              r_Serve_To_P2 <= 1'b1;
            end else begin
              r_Cnt <= r_Cnt + 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (w_Tick) begin
            if (r_Cnt == LAST_SERVE) begin
              r_State  <= ST_PLAY;
              r_Cnt    <= '0;
              r_Active <= 1'b1;
            end else begin
              r_Cnt <= r_Cnt + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (i_P1_Miss || i_P2_Miss) begin
            r_Active <= 1'b0;
            r_Cnt    <= '0;
            r_State  <= ST_SERVE;
          end
          // A double miss is a replay: no point, same server.
          if (i_P1_Miss && !i_P2_Miss) begin
            r_P2_Score    <= w_P2_Next;
            r_Serve_To_P2 <= 1'b0;
            if (w_P2_Next == LIMIT) begin
              r_State  <= ST_OVER;
              r_Winner <= WIN_P2;
            end
          end else if (i_P2_Miss && !i_P1_Miss) begin
            r_P1_Score    <= w_P1_Next;
            r_Serve_To_P2 <= 1'b1;
            if (w_P1_Next == LIMIT) begin
              r_State  <= ST_OVER;
              r_Winner <= WIN_P1;
            end
          end
        end
        ST_OVER: begin
          if (w_Tick) begin
            if (r_Cnt == LAST_OVER) begin
              r_State <= ST_IDLE;
              r_Cnt   <= '0;
            end else begin
              r_Cnt <= r_Cnt + 1'b1;
            end
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign o_Game_Active = r_Active;
  assign o_Serve_To_P2 = r_Serve_To_P2;
  assign o_P1_Score    = r_P1_Score;
  assign o_P2_Score    = r_P2_Score;
  assign o_Winner      = r_Winner;
  assign o_State       = r_State;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with small frame counts and SCORE_LIMIT=2.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       vsync;
  logic       start_a_l;
  logic       start_b_l;
  logic       p1_miss;
  logic       p2_miss;
  logic       game_active;
  logic       serve_to_p2;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  pong_match_ctrl #(
    .SCORE_LIMIT  (2),
    .ARM_FRAMES   (3),
    .SERVE_FRAMES (2),
    .OVER_FRAMES  (3)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_l),
    .i_VSync       (vsync),
    .i_Start_A_L   (start_a_l),
    .i_Start_B_L   (start_b_l),
    .i_P1_Miss     (p1_miss),
    .i_P2_Miss     (p2_miss),
    .o_Game_Active (game_active),
    .o_Serve_To_P2 (serve_to_p2),
    .o_P1_Score    (p1_score),
    .o_P2_Score    (p2_score),
    .o_Winner      (winner),
    .o_State       (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One VSync falling edge: exactly one frame tick, then one idle cycle.
  task automatic frame();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_l = 1'b0; vsync = 1'b1; start_a_l = 1'b1; start_b_l = 1'b1;
    p1_miss = 1'b0; p2_miss = 1'b0;
    step(); step();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
    n_tests++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %0b exp 0", game_active); end
    n_tests++; if (serve_to_p2 !== 1'b1) begin n_fail++; $display("FAIL reset_serve got %0b exp 1", serve_to_p2); end
    n_tests++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin n_fail++; $display("FAIL reset_scores got %0d/%0d exp 0/0", p1_score, p2_score); end
    n_tests++; if (winner !== 2'b00) begin n_fail++; $display("FAIL reset_winner got %0b exp 00", winner); end
    rst_l = 1'b1;
    step(); step();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset_idle got %0d exp 0", state); end
  endtask

  task automatic test_arm_release();
    start_a_l = 1'b0; start_b_l = 1'b0;
    step();
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL arm_enter got %0d exp 1", state); end
    frame(); frame();
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL arm_hold2 got %0d exp 1", state); end
    start_a_l = 1'b1;
    step();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL arm_release got %0d exp 0", state); end
    start_b_l = 1'b1;
    step();
  endtask

  task automatic test_arm();
    start_a_l = 1'b0; start_b_l = 1'b0;
    step();
    frame(); frame();
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL arm_before3 got %0d exp 1", state); end
    frame();
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL arm_to_serve got %0d exp 2", state); end
    n_tests++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin n_fail++; $display("FAIL arm_scores got %0d/%0d exp 0/0", p1_score, p2_score); end
    n_tests++; if (serve_to_p2 !== 1'b1) begin n_fail++; $display("FAIL arm_serve got %0b exp 1", serve_to_p2); end
    start_a_l = 1'b1; start_b_l = 1'b1;
  endtask

  task automatic test_serve();
    p1_miss = 1'b1;
    step();
    p1_miss = 1'b0;
    n_tests++; if (state !== 3'd2 || p2_score !== 4'd0) begin n_fail++; $display("FAIL serve_miss_ignored state %0d p2 %0d exp 2/0", state, p2_score); end
    frame();
    n_tests++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL serve_after1 active %0b exp 0", game_active); end
    vsync = 1'b0;
    #1;
    n_tests++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL serve_tick2_cycle active %0b exp 0", game_active); end
    step();
    n_tests++; if (game_active !== 1'b1 || state !== 3'd3) begin n_fail++; $display("FAIL serve_to_play active %0b state %0d exp 1/3", game_active, state); end
    vsync = 1'b1;
    step();
  endtask

  task automatic test_miss();
    p1_miss = 1'b1;
    step();
    p1_miss = 1'b0;
    n_tests++; if (p2_score !== 4'd1 || p1_score !== 4'd0) begin n_fail++; $display("FAIL miss_scores got %0d/%0d exp 0/1", p1_score, p2_score); end
    n_tests++; if (serve_to_p2 !== 1'b0) begin n_fail++; $display("FAIL miss_serve got %0b exp 0", serve_to_p2); end
    n_tests++; if (game_active !== 1'b0 || state !== 3'd2) begin n_fail++; $display("FAIL miss_to_serve active %0b state %0d exp 0/2", game_active, state); end
    frame(); frame();
  endtask

  task automatic test_simultaneous();
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL simul_pre_play got %0d exp 3", state); end
    p1_miss = 1'b1; p2_miss = 1'b1;
    step();
    p1_miss = 1'b0; p2_miss = 1'b0;
    n_tests++; if (p1_score !== 4'd0 || p2_score !== 4'd1) begin n_fail++; $display("FAIL simul_scores got %0d/%0d exp 0/1", p1_score, p2_score); end
    n_tests++; if (state !== 3'd2 || serve_to_p2 !== 1'b0) begin n_fail++; $display("FAIL simul_state state %0d serve %0b exp 2/0", state, serve_to_p2); end
    p2_miss = 1'b1;
    step();
    p2_miss = 1'b0;
    n_tests++; if (p1_score !== 4'd0 || state !== 3'd2) begin n_fail++; $display("FAIL simul_serve_ignore p1 %0d state %0d exp 0/2", p1_score, state); end
    frame(); frame();
  endtask

  task automatic test_win();
    p2_miss = 1'b1;
    step();
    p2_miss = 1'b0;
    n_tests++; if (p1_score !== 4'd1 || serve_to_p2 !== 1'b1 || state !== 3'd2) begin n_fail++; $display("FAIL win_pre p1 %0d serve %0b state %0d exp 1/1/2", p1_score, serve_to_p2, state); end
    frame(); frame();
    p2_miss = 1'b1;
    step();
    p2_miss = 1'b0;
    n_tests++; if (p1_score !== 4'd2 || winner !== 2'b01) begin n_fail++; $display("FAIL win_score p1 %0d winner %0b exp 2/01", p1_score, winner); end
    n_tests++; if (state !== 3'd4 || game_active !== 1'b0) begin n_fail++; $display("FAIL win_over state %0d active %0b exp 4/0", state, game_active); end
    p1_miss = 1'b1;
    step();
    p1_miss = 1'b0;
    n_tests++; if (p2_score !== 4'd1) begin n_fail++; $display("FAIL over_miss_ignored p2 %0d exp 1", p2_score); end
    frame(); frame();
    n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL over_hold got %0d exp 4", state); end
    frame();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL over_to_idle got %0d exp 0", state); end
    n_tests++; if (winner !== 2'b01 || p1_score !== 4'd2 || p2_score !== 4'd1) begin n_fail++; $display("FAIL over_kept winner %0b p1 %0d p2 %0d exp 01/2/1", winner, p1_score, p2_score); end
  endtask

  task automatic test_rearm();
    start_a_l = 1'b0; start_b_l = 1'b0;
    step();
    frame(); frame(); frame();
    start_a_l = 1'b1; start_b_l = 1'b1;
    n_tests++; if (state !== 3'd2 || winner !== 2'b00) begin n_fail++; $display("FAIL rearm state %0d winner %0b exp 2/00", state, winner); end
    n_tests++; if (p1_score !== 4'd0 || p2_score !== 4'd0 || serve_to_p2 !== 1'b1) begin n_fail++; $display("FAIL rearm_clear %0d/%0d serve %0b exp 0/0/1", p1_score, p2_score, serve_to_p2); end
    frame(); frame();
  endtask

  task automatic test_reset_mid_play();
    p1_miss = 1'b1;
    step();
    p1_miss = 1'b0;
    frame(); frame();
    n_tests++; if (game_active !== 1'b1) begin n_fail++; $display("FAIL mid_pre_active got %0b exp 1", game_active); end
    #2;
    rst_l = 1'b0;
    #1;
    n_tests++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL mid_reset_active got %0b exp 0", game_active); end
    n_tests++; if (state !== 3'd0 || serve_to_p2 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_state %0d serve %0b exp 0/1", state, serve_to_p2); end
    n_tests++; if (p1_score !== 4'd0 || p2_score !== 4'd0 || winner !== 2'b00) begin n_fail++; $display("FAIL mid_reset_scores %0d/%0d winner %0b exp 0/0/00", p1_score, p2_score, winner); end
    step();
    rst_l = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_arm_release();
    test_arm();
    test_serve();
    test_miss();
    test_simultaneous();
    test_win();
    test_rearm();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
